key_press_gen: RTL and testbench

- Synthesizable key-press emulator that drives an active-low, bouncy key line. It is the transmitting end of the key interface that the key debounce filters consume.
- On a one-cycle request it produces a press sequence: pseudo-random press bounce, a clean low hold, pseudo-random release bounce, then a return to idle high.
- It is used in board self-test and in benches to exercise the debounce and beep path with deterministic, repeatable glitches.
- Instantiate one per key line.

---
 rtl/key_pkg.sv | 28 ++
 rtl/key_press_gen_if.sv | 30 +++
 rtl/lfsr16.sv | 26 ++
 rtl/key_press_gen.sv | 161 ++++++++++++++++
 tb/tb_key_press_gen.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key-press emulator: FSM encoding, LFSR taps
// and the idle level of the active-low key line.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS_B = 2'd1,
    HOLD    = 2'd2,
    REL_B   = 2'd3
  } key_state_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Released key reads high
  localparam logic KEY_IDLE = 1'b1;

  // Feedback bit shifted into bit 0 on the next advance
  function automatic logic lfsr_fb(input logic [15:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

  // One left shift of the LFSR with feedback into bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], lfsr_fb(q)};
  endfunction

endpackage

// File: rtl/key_press_gen_if.sv
// Request/status bundle between a key-press requester and the emulator.
interface key_press_gen_if #(
  parameter int HOLD_W = 20
) ();

  logic              press_req;
  logic [HOLD_W-1:0] hold_cycles;
  logic              key_out;
  logic              busy;
  logic              done;

  // Requester side: issues presses and watches the key line
  modport master (
    output press_req,
    output hold_cycles,
    input  key_out,
    input  busy,
    input  done
  );

  // Emulator side: accepts presses and drives the key line
  modport slave (
    input  press_req,
    input  hold_cycles,
    output key_out,
    output busy,
    output done
  );

endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that supplies the bounce glitch pattern.
module lfsr16
  import key_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] r_q;

  // Reload the seed on reset, otherwise advance only when enabled
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_q <= SEED;
    end else if (en) begin
      r_q <= lfsr_step(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/key_press_gen.sv
// Key-press emulator: on request drives an active-low key line through
// press bounce, a clean low hold, release bounce and back to idle high.
module key_press_gen
  import key_pkg::*;
#(
  parameter logic [19:0] BOUNCE_CNT = 20'd20,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          HOLD_W     = 20
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  key_press_gen_if.slave  kif
);

  localparam bit                BOUNCE_EN   = (BOUNCE_CNT != 20'd0);
  localparam logic [19:0]       BOUNCE_LAST = BOUNCE_CNT - 20'd1;
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

  key_state_t        r_state;
  logic              r_key;
  logic              r_busy;
  logic              r_done;
  logic [19:0]       r_bcnt;
  logic [HOLD_W-1:0] r_hcnt;
  logic [HOLD_W-1:0] r_hold_len;

  key_state_t        w_state_next;
  logic              w_key_next;
  logic              w_busy_next;
  logic              w_done_next;
  logic [19:0]       w_bcnt_next;
  logic [HOLD_W-1:0] w_hcnt_next;
  logic [HOLD_W-1:0] w_hold_len_next;

  logic [15:0]       w_lfsr_q;
  logic              w_lfsr_en;
  logic              w_lfsr_next_bit;
  logic              w_bounce_last;
  logic              w_hold_last;

  assign w_lfsr_en       = (r_state == PRESS_B) || (r_state == REL_B);
  assign w_lfsr_next_bit = lfsr_fb(w_lfsr_q);
  assign w_bounce_last   = (r_bcnt == BOUNCE_LAST);
  assign w_hold_last     = (r_hcnt == (r_hold_len - HOLD_ONE));

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (w_lfsr_en),
    .q       (w_lfsr_q)
  );

  // Register the FSM state, counters and outputs computed below
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= IDLE;
      r_key      <= KEY_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcnt     <= '0;
      r_hcnt     <= '0;
      r_hold_len <= '0;
    end else begin
      r_state    <= w_state_next;
      r_key      <= w_key_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_bcnt     <= w_bcnt_next;
      r_hcnt     <= w_hcnt_next;
      r_hold_len <= w_hold_len_next;
    end
  end

  // Next state and next output values; the edge entering a state sets the
  // key level seen during that state's first cycle
  always_comb begin
    w_state_next    = r_state;
    w_key_next      = r_key;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;
    w_bcnt_next     = r_bcnt;
    w_hcnt_next     = r_hcnt;
    w_hold_len_next = r_hold_len;

    case (r_state)
      IDLE: begin
        w_key_next  = KEY_IDLE;
        w_busy_next = 1'b0;
        if (kif.press_req) begin
          w_hold_len_next = (kif.hold_cycles == '0) ? HOLD_ONE : kif.hold_cycles;
          w_busy_next     = 1'b1;
          w_bcnt_next     = '0;
          w_hcnt_next     = '0;
          if (BOUNCE_EN) begin
            w_state_next = PRESS_B;
          end else begin
            w_state_next = HOLD;
            w_key_next   = 1'b0;
          end
        end
      end

      PRESS_B: begin
        if (w_bounce_last) begin
          w_state_next = HOLD;
          w_key_next   = 1'b0;
          w_bcnt_next  = '0;
          w_hcnt_next  = '0;
        end else begin
          w_key_next  = w_lfsr_q[0];
          w_bcnt_next = r_bcnt + 20'd1;
        end
      end

      HOLD: begin
        if (w_hold_last) begin
          w_hcnt_next = '0;
          if (BOUNCE_EN) begin
            w_state_next = REL_B;
            w_key_next   = w_lfsr_q[0];
            w_bcnt_next  = '0;
          end else begin
            w_state_next = IDLE;
            w_key_next   = KEY_IDLE;
            w_done_next  = 1'b1;
            w_busy_next  = 1'b0;
          end
        end else begin
          w_key_next  = 1'b0;
          w_hcnt_next = r_hcnt + HOLD_ONE;
        end
      end

      REL_B: begin
        if (w_bounce_last) begin
          w_state_next = IDLE;
          w_key_next   = KEY_IDLE;
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
          w_bcnt_next  = '0;
        end else begin
          w_key_next  = w_lfsr_next_bit;
          w_bcnt_next = r_bcnt + 20'd1;
        end
      end

      default: begin
        w_state_next = IDLE;
        w_key_next   = KEY_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  assign kif.key_out = r_key;
  assign kif.busy    = r_busy;
  assign kif.done    = r_done;

endmodule

// File: tb/tb_key_press_gen.sv
// Directed bench for key_press_gen: one instance without bounce and one
// with 20-cycle bounce, checked against hand-derived sequences and a
// reference LFSR.
module tb_key_press_gen;

  logic        sysClk;
  logic        sysRst;
  int          checks;
  int          errors;
  logic [15:0] refLfsr;

  key_press_gen_if #(.HOLD_W(20)) kifClean ();
  key_press_gen_if #(.HOLD_W(20)) kifBounce ();

  key_press_gen #(
    .BOUNCE_CNT (20'd0),
    .LFSR_SEED  (16'hACE1),
    .HOLD_W     (20)
  ) dutClean (
    .sys_clk (sysClk),
    .sys_rst (sysRst),
    .kif     (kifClean)
  );

  key_press_gen #(
    .BOUNCE_CNT (20'd20),
    .LFSR_SEED  (16'hACE1),
    .HOLD_W     (20)
  ) dutBounce (
    .sys_clk (sysClk),
    .sys_rst (sysRst),
    .kif     (kifBounce)
  );

  // Free-running 10-unit clock
  initial begin
    sysClk = 1'b0;
    forever #5 sysClk = ~sysClk;
  end

  // Reference LFSR written from the tap list 16,14,13,11
  function automatic logic [15:0] refStep(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full press on the bouncing instance, starting from refLfsr
  task automatic bouncePress(input int holdLen, input bit pulseWhileBusy, input string tag);
    kifBounce.hold_cycles = 20'(holdLen);
    kifBounce.press_req   = 1'b1;
    tick();
    kifBounce.press_req   = 1'b0;
    checkOutput({tag, " first"}, 32'(kifBounce.key_out), 32'd1);
    checkOutput({tag, " busy on accept"}, 32'(kifBounce.busy), 32'd1);
    for (int i = 0; i < 19; i++) begin
      tick();
      checkOutput({tag, " press bounce"}, 32'(kifBounce.key_out), 32'(refLfsr[0]));
      checkOutput({tag, " press busy"}, 32'(kifBounce.busy), 32'd1);
      refLfsr = refStep(refLfsr);
      if (pulseWhileBusy && i == 0) kifBounce.hold_cycles = 20'd7;
      if (pulseWhileBusy && i == 1) kifBounce.press_req = 1'b1;
      if (pulseWhileBusy && i == 2) kifBounce.press_req = 1'b0;
    end
    refLfsr = refStep(refLfsr);
    for (int i = 0; i < holdLen; i++) begin
      tick();
      checkOutput({tag, " hold low"}, 32'(kifBounce.key_out), 32'd0);
      checkOutput({tag, " hold no done"}, 32'(kifBounce.done), 32'd0);
      if (pulseWhileBusy && i == 29) kifBounce.press_req = 1'b1;
      if (pulseWhileBusy && i == 30) kifBounce.press_req = 1'b0;
    end
    for (int j = 0; j < 20; j++) begin
      tick();
      checkOutput({tag, " release bounce"}, 32'(kifBounce.key_out), 32'(refLfsr[0]));
      checkOutput({tag, " release busy"}, 32'(kifBounce.busy), 32'd1);
      refLfsr = refStep(refLfsr);
    end
    tick();
    checkOutput({tag, " end key"}, 32'(kifBounce.key_out), 32'd1);
    checkOutput({tag, " end done"}, 32'(kifBounce.done), 32'd1);
    checkOutput({tag, " end busy"}, 32'(kifBounce.busy), 32'd0);
    tick();
    checkOutput({tag, " done single"}, 32'(kifBounce.done), 32'd0);
    checkOutput({tag, " idle key"}, 32'(kifBounce.key_out), 32'd1);
  endtask

  // Directed sequence of all scenarios
  initial begin
    checks = 0;
    errors = 0;
    sysRst = 1'b1;
    kifClean.press_req    = 1'b0;
    kifClean.hold_cycles  = 20'd0;
    kifBounce.press_req   = 1'b0;
    kifBounce.hold_cycles = 20'd0;

    tick();
    tick();
    tick();
    checkOutput("reset clean key", 32'(kifClean.key_out), 32'd1);
    checkOutput("reset clean busy", 32'(kifClean.busy), 32'd0);
    checkOutput("reset clean done", 32'(kifClean.done), 32'd0);
    checkOutput("reset bounce key", 32'(kifBounce.key_out), 32'd1);
    checkOutput("reset bounce busy", 32'(kifBounce.busy), 32'd0);
    checkOutput("reset bounce done", 32'(kifBounce.done), 32'd0);
    sysRst = 1'b0;
    tick();

    $display("[TB] clean press, hold 5");
    kifClean.hold_cycles = 20'd5;
    kifClean.press_req   = 1'b1;
    tick();
    kifClean.press_req   = 1'b0;
    kifClean.hold_cycles = 20'd9;
    for (int c = 0; c < 5; c++) begin
      checkOutput("clean low", 32'(kifClean.key_out), 32'd0);
      checkOutput("clean busy", 32'(kifClean.busy), 32'd1);
      checkOutput("clean no done", 32'(kifClean.done), 32'd0);
      tick();
    end
    checkOutput("clean end key", 32'(kifClean.key_out), 32'd1);
    checkOutput("clean end done", 32'(kifClean.done), 32'd1);
    checkOutput("clean end busy", 32'(kifClean.busy), 32'd0);
    tick();
    checkOutput("clean done single", 32'(kifClean.done), 32'd0);

    $display("[TB] bounce press, hold 100, requests while busy");
    refLfsr = 16'hACE1;
    bouncePress(100, 1'b1, "bounce1");

    $display("[TB] reset in the middle of hold");
    kifBounce.hold_cycles = 20'd100;
    kifBounce.press_req   = 1'b1;
    tick();
    kifBounce.press_req   = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    checkOutput("midhold low", 32'(kifBounce.key_out), 32'd0);
    sysRst = 1'b1;
    tick();
    checkOutput("midreset key", 32'(kifBounce.key_out), 32'd1);
    checkOutput("midreset busy", 32'(kifBounce.busy), 32'd0);
    checkOutput("midreset done", 32'(kifBounce.done), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    sysRst = 1'b0;
    tick();
    checkOutput("postreset done", 32'(kifBounce.done), 32'd0);
    checkOutput("postreset key", 32'(kifBounce.key_out), 32'd1);
    refLfsr = 16'hACE1;
    bouncePress(3, 1'b0, "reseeded");

    $display("[TB] back-to-back with zero hold");
    kifClean.hold_cycles = 20'd0;
    kifClean.press_req   = 1'b1;
    tick();
    for (int n = 0; n < 3; n++) begin
      checkOutput("b2b low", 32'(kifClean.key_out), 32'd0);
      checkOutput("b2b busy", 32'(kifClean.busy), 32'd1);
      checkOutput("b2b no done", 32'(kifClean.done), 32'd0);
      tick();
      checkOutput("b2b end key", 32'(kifClean.key_out), 32'd1);
      checkOutput("b2b end done", 32'(kifClean.done), 32'd1);
      checkOutput("b2b end busy", 32'(kifClean.busy), 32'd0);
      if (n == 2) kifClean.press_req = 1'b0;
      tick();
    end
    checkOutput("b2b stop key", 32'(kifClean.key_out), 32'd1);
    checkOutput("b2b stop busy", 32'(kifClean.busy), 32'd0);
    checkOutput("b2b stop done", 32'(kifClean.done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
